// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives imem, pairs each 1-cycle-late word with its PC.
// Stall freezes the PC and captures the delivered word; redirect squashes the in-flight fetch.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd_data,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_insn
);

    logic [31:0] r_pc;
    logic [31:0] r_resp_pc;
    logic        r_resp_valid;
    logic        r_hold;
    logic [31:0] r_hold_insn;

    logic [31:0] w_target;
    logic [31:0] w_insn;

    assign w_target  = redirect_pc & ~32'h3;
    assign imem_addr = r_pc;

    // The captured word stays authoritative until the stall releases; imem keeps re-reading r_pc meanwhile.
    assign w_insn    = r_hold ? r_hold_insn : imem_rd_data;

    assign if_valid  = r_resp_valid;
    assign if_pc     = r_resp_pc;
    assign if_insn   = r_resp_valid ? w_insn : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_resp_pc    <= 32'h0;
            r_resp_valid <= 1'b0;
            r_hold       <= 1'b0;
            r_hold_insn  <= 32'h0;
        end else if (redirect_valid) begin
            r_pc         <= w_target;
            r_resp_valid <= 1'b0;
            r_hold       <= 1'b0;
        end else if (stall) begin
            if (!r_hold && r_resp_valid) begin
                r_hold_insn <= imem_rd_data;
                r_hold      <= 1'b1;
            end
        end else begin
            r_resp_pc    <= r_pc;
            r_resp_valid <= 1'b1;
            r_pc         <= r_pc + 32'd4;
            r_hold       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, async-reset sequence, then random stall/redirect vs. a stream model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_insn;

    int total = 0;
    int bad   = 0;

    fetch_unit #(.RESET_PC(32'h0000_8000)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rd_data   (imem_rd_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_insn        (if_insn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image: a distinct word per address, used by both imem and the checks.
    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return {a[17:2], ~a[17:2]} ^ 32'h1357_9BDF;
    endfunction

    always @(posedge clk) imem_rd_data <= insn_of(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        s;
        logic        r;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl[19];

    task automatic setv(input int i, input logic s, input logic r, input logic [31:0] rpc,
                        input logic ev, input logic [31:0] epc, input logic [31:0] eaddr);
        tbl[i].s = s; tbl[i].r = r; tbl[i].rpc = rpc;
        tbl[i].ev = ev; tbl[i].epc = epc; tbl[i].eaddr = eaddr;
    endtask

    task automatic do_reset();
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Stream model: what decode should see, derived from fetch order, not from RTL state.
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_fetch;

    task automatic model_check();
        chk("rnd_addr", imem_addr, m_fetch);
        chk("rnd_valid", {31'h0, if_valid}, {31'h0, m_valid});
        if (m_valid) begin
            chk("rnd_pc", if_pc, m_pc);
            chk("rnd_insn", if_insn, insn_of(m_pc));
        end
    endtask

    task automatic model_step(input logic s, input logic r, input logic [31:0] t);
        if (r) begin
            m_fetch = {t[31:2], 2'b00};
            m_valid = 1'b0;
        end else if (!s) begin
            m_valid = 1'b1;
            m_pc    = m_fetch;
            m_fetch = m_fetch + 32'd4;
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

        setv(0,  0, 0, 32'h0,         0, 32'h0,         32'h8000);
        setv(1,  0, 0, 32'h0,         1, 32'h8000,      32'h8004);
        setv(2,  0, 0, 32'h0,         1, 32'h8004,      32'h8008);
        setv(3,  1, 0, 32'h0,         1, 32'h8008,      32'h800C);
        setv(4,  1, 0, 32'h0,         1, 32'h8008,      32'h800C);
        setv(5,  1, 0, 32'h0,         1, 32'h8008,      32'h800C);
        setv(6,  0, 0, 32'h0,         1, 32'h8008,      32'h800C);
        setv(7,  0, 0, 32'h0,         1, 32'h800C,      32'h8010);
        setv(8,  0, 1, 32'h8100,      1, 32'h8010,      32'h8014);
        setv(9,  0, 0, 32'h0,         0, 32'h0,         32'h8100);
        setv(10, 1, 0, 32'h0,         1, 32'h8100,      32'h8104);
        setv(11, 1, 1, 32'h8102,      1, 32'h8100,      32'h8104);
        setv(12, 0, 0, 32'h0,         0, 32'h0,         32'h8100);
        setv(13, 0, 0, 32'h0,         1, 32'h8100,      32'h8104);
        setv(14, 0, 1, 32'hFFFF_FFF8, 1, 32'h8104,      32'h8108);
        setv(15, 0, 0, 32'h0,         0, 32'h0,         32'hFFFF_FFF8);
        setv(16, 0, 0, 32'h0,         1, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
        setv(17, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 32'h0000_0000);
        setv(18, 0, 0, 32'h0,         1, 32'h0000_0000, 32'h0000_0004);

        do_reset();
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_insn", if_insn, 32'h0);

        for (int i = 0; i < 19; i++) begin
            chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].eaddr);
            chk($sformatf("vec%0d_valid", i), {31'h0, if_valid}, {31'h0, tbl[i].ev});
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_pc", i), if_pc, tbl[i].epc);
                chk($sformatf("vec%0d_insn", i), if_insn, insn_of(tbl[i].epc));
            end
            stall = tbl[i].s; redirect_valid = tbl[i].r; redirect_pc = tbl[i].rpc;
            @(negedge clk);
        end

        // Async reset in the middle of a stall.
        stall = 1'b1; redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_arst_valid", {31'h0, if_valid}, 32'h1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'h0, if_valid}, 32'h0);
        chk("arst_pc", if_pc, 32'h0);
        chk("arst_insn", if_insn, 32'h0);
        chk("arst_addr", imem_addr, 32'h8000);
        @(negedge clk);
        rst = 1'b0; stall = 1'b0;
        chk("restart0_valid", {31'h0, if_valid}, 32'h0);
        chk("restart0_insn", if_insn, 32'h0);
        @(negedge clk);
        chk("restart1_pc", if_pc, 32'h8000);
        chk("restart1_insn", if_insn, insn_of(32'h8000));
        @(negedge clk);
        chk("restart2_pc", if_pc, 32'h8004);
        chk("restart2_insn", if_insn, insn_of(32'h8004));

        // Randomized traffic against the stream model.
        do_reset();
        m_valid = 1'b0; m_pc = 32'h0; m_fetch = 32'h8000;
        for (int c = 0; c < 3000; c++) begin
            logic        s, r;
            logic [31:0] t;
            model_check();
            s = ($urandom_range(0, 99) < 30);
            r = ($urandom_range(0, 99) < 8);
            t = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFE0 | $urandom_range(0, 31))
                                             : (32'h0000_8000 + $urandom_range(0, 4095));
            stall = s; redirect_valid = r; redirect_pc = t;
            model_step(s, r, t);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
